// File: rtl/gf_mult_iter.sv
// Iterative GF(2^WIDTH) multiplier. Each busy cycle it consumes DIGIT multiplier
// bits, LSB first. Latency is WIDTH/DIGIT cycles with no early exit.
// Optional build macro GF_MULT_ACCUM_EN adds an in_acc port. When in_acc is set,
// the new product is XORed into the previous z (GHASH-style chaining).
module gf_mult_iter #(
  parameter int              WIDTH = 128,
  parameter int              DIGIT = 8,
  parameter logic [WIDTH-1:0] POLY = 'h87
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
`ifdef GF_MULT_ACCUM_EN
  input  logic             in_acc,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z
);

  // Guarded so a bad DIGIT reaches the elaboration check instead of dividing by zero.
  localparam int NumCyc = (DIGIT >= 1) ? WIDTH / DIGIT : 1;
  localparam int CntW   = $clog2(NumCyc + 1);

  if (DIGIT < 1) begin : g_bad_digit
    $error("gf_mult_iter: DIGIT must be at least 1");
  end else if (WIDTH < 2) begin : g_bad_width
    $error("gf_mult_iter: WIDTH must be at least 2");
  end else if (WIDTH % DIGIT != 0) begin : g_bad_ratio
    $error("gf_mult_iter: WIDTH must be a multiple of DIGIT");
  end

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] ysh_q, ysh_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] z_q, z_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] m_step, acc_step;
  logic [WIDTH-1:0] z_prev;

`ifdef GF_MULT_ACCUM_EN
  logic chain_q, chain_d;
  assign z_prev = chain_q ? z_q : '0;
`else
  assign z_prev = '0;
`endif

  // One digit of shift-and-add: conditionally accumulate m, then multiply m by alpha.
  always_comb begin
    m_step   = m_q;
    acc_step = acc_q;
    for (int j = 0; j < DIGIT; j++) begin
      if (ysh_q[j]) acc_step = acc_step ^ m_step;
      m_step = {m_step[WIDTH-2:0], 1'b0} ^ (m_step[WIDTH-1] ? POLY : '0);
    end
  end

  // FSM next state, datapath next state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    ysh_d     = ysh_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    z_d       = z_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
`ifdef GF_MULT_ACCUM_EN
    chain_d   = chain_q;
`endif
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          m_d     = x;
          ysh_d   = y;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = StBusy;
`ifdef GF_MULT_ACCUM_EN
          chain_d = in_acc;
`endif
        end
      end
      StBusy: begin
        m_d   = m_step;
        acc_d = acc_step;
        ysh_d = ysh_q >> DIGIT;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(NumCyc - 1)) begin
          z_d     = acc_step ^ z_prev;
          state_d = StDone;
        end
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset; reset clears any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      m_q     <= '0;
      ysh_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      z_q     <= '0;
`ifdef GF_MULT_ACCUM_EN
      chain_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      ysh_q   <= ysh_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      z_q     <= z_d;
`ifdef GF_MULT_ACCUM_EN
      chain_q <= chain_d;
`endif
    end
  end

  assign z = z_q;

endmodule

// File: tb/tb_gf_mult_iter.sv
// Bench for gf_mult_iter: three instances (DIGIT 1, 8 and 32) at WIDTH=128, checked
// against a carry-less-multiply-then-reduce reference model.
module tb_gf_mult_iter;

  localparam int W = 128;
  localparam logic [W-1:0] Poly = 128'h87;

  logic clk = 1'b0;
  logic rst, out_ready;
  logic iv1, iv8, iv32;
  logic ir1, ir8, ir32;
  logic ov1, ov8, ov32;
  logic [W-1:0] x, y, z1, z8, z32;
`ifdef GF_MULT_ACCUM_EN
  logic in_acc;
`endif

  int tests = 0;
  int fails = 0;
  logic [W-1:0] prev_z8 = '0;
  logic [W-1:0] got1, got8, got32;
  int lat1, lat8, lat32;

  always #5 clk = ~clk;

  gf_mult_iter #(.WIDTH(W), .DIGIT(1)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .x(x), .y(y),
`ifdef GF_MULT_ACCUM_EN
    .in_acc(in_acc),
`endif
    .out_valid(ov1), .out_ready(out_ready), .z(z1)
  );

  gf_mult_iter #(.WIDTH(W), .DIGIT(8)) u_d8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .x(x), .y(y),
`ifdef GF_MULT_ACCUM_EN
    .in_acc(in_acc),
`endif
    .out_valid(ov8), .out_ready(out_ready), .z(z8)
  );

  gf_mult_iter #(.WIDTH(W), .DIGIT(32)) u_d32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .x(x), .y(y),
`ifdef GF_MULT_ACCUM_EN
    .in_acc(in_acc),
`endif
    .out_valid(ov32), .out_ready(out_ready), .z(z32)
  );

  // Polynomial product over GF(2), then reduction modulo x^128 + POLY.
  function automatic logic [W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] p;
    logic [2*W-1:0] pf;
    p  = '0;
    pf = {{(W-1){1'b0}}, 1'b1, Poly};
    for (int i = 0; i < W; i++)
      if (b[i]) p = p ^ ({{W{1'b0}}, a} << i);
    for (int k = 2*W-1; k >= W; k--)
      if (p[k]) p = p ^ (pf << (k - W));
    return p[W-1:0];
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Launch one operation on the DUTs selected by mask {d32, d8, d1} and collect results.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] mask);
    int guard;
    logic [2:0] seen;
    guard = 0;
    while (!((ir1 || !mask[0]) && (ir8 || !mask[1]) && (ir32 || !mask[2])) && guard < 300) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 300) begin
      tests++; fails++;
      $display("FAIL idle_wait: got in_ready=%b%b%b expected all ready", ir32, ir8, ir1);
    end
    x = a; y = b;
    iv1 = mask[0]; iv8 = mask[1]; iv32 = mask[2];
    @(posedge clk); #1;
    iv1 = 1'b0; iv8 = 1'b0; iv32 = 1'b0;
    seen = '0;
    lat1 = 0; lat8 = 0; lat32 = 0;
    got1 = 'x; got8 = 'x; got32 = 'x;
    for (int c = 1; c <= 300; c++) begin
      @(posedge clk); #1;
      if (c == 1 && mask[1]) chk("z_hold_busy", z8, prev_z8);
      if (mask[0] && !seen[0] && ov1) begin seen[0] = 1'b1; lat1 = c; got1 = z1; end
      if (mask[1] && !seen[1] && ov8) begin seen[1] = 1'b1; lat8 = c; got8 = z8; end
      if (mask[2] && !seen[2] && ov32) begin seen[2] = 1'b1; lat32 = c; got32 = z32; end
      if ((seen | ~mask) == 3'b111) break;
    end
    if ((seen | ~mask) != 3'b111) begin
      tests++; fails++;
      $display("FAIL out_valid_timeout: got seen=%b expected %b", seen, mask);
    end
    if (seen[1]) prev_z8 = got8;
  endtask

  task automatic check_res(input string name, input logic [2:0] mask, input logic [W-1:0] exp);
    if (mask[0]) begin
      chk({name, "_z_d1"}, got1, exp);
      chk({name, "_lat_d1"}, W'(lat1), W'(128));
    end
    if (mask[1]) begin
      chk({name, "_z_d8"}, got8, exp);
      chk({name, "_lat_d8"}, W'(lat8), W'(16));
    end
    if (mask[2]) begin
      chk({name, "_z_d32"}, got32, exp);
      chk({name, "_lat_d32"}, W'(lat32), W'(4));
    end
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;

  initial begin
    vec_t tbl[6];
    logic [W-1:0] ra, rb;
    logic [2:0] m;
    int lat, nov;

    tbl[0] = '{a: 128'h1, b: 128'h1, exp: 128'h1};
    tbl[1] = '{a: {1'b1, 127'h0}, b: 128'h2, exp: 128'h87};
    tbl[2] = '{a: 128'h2, b: {1'b1, 127'h0}, exp: 128'h87};
    tbl[3] = '{a: 128'h0, b: {W{1'b1}}, exp: 128'h0};
    tbl[4] = '{a: 128'h1234, b: 128'h0, exp: 128'h0};
    tbl[5] = '{a: 128'h3, b: 128'h3, exp: 128'h5};

    rst = 1'b1; out_ready = 1'b1; iv1 = 1'b0; iv8 = 1'b0; iv32 = 1'b0;
    x = '0; y = '0;
`ifdef GF_MULT_ACCUM_EN
    in_acc = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("reset_z", z8, '0);
    chk("reset_out_valid", W'({ov32, ov8, ov1}), W'(0));
    chk("reset_in_ready", W'({ir32, ir8, ir1}), W'(3'b111));
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_op(tbl[i].a, tbl[i].b, 3'b111);
      check_res($sformatf("vec%0d", i), 3'b111, tbl[i].exp);
    end

    // Back-pressure: result and out_valid must hold while out_ready is low.
    out_ready = 1'b0;
    x = 128'h1234; y = '0; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (ov8) begin lat = c; break; end
    end
    chk("stall_lat", W'(lat), W'(16));
    chk("stall_z", z8, '0);
    repeat (5) begin
      @(posedge clk); #1;
      chk("stall_out_valid", W'(ov8), W'(1));
      chk("stall_z_hold", z8, '0);
      chk("stall_in_ready", W'(ir8), W'(0));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_out_valid", W'(ov8), W'(0));
    chk("release_in_ready", W'(ir8), W'(1));
    prev_z8 = '0;

    // Leave a nonzero result in every DUT so the reset clear is visible.
    run_op(128'h3, 128'h3, 3'b111);
    check_res("prereset", 3'b111, 128'h5);

    // Reset during busy cycle 7, with in_valid raised at the same edge.
    x = {$urandom, $urandom, $urandom, $urandom};
    y = {$urandom, $urandom, $urandom, $urandom};
    iv1 = 1'b1; iv8 = 1'b1; iv32 = 1'b1;
    @(posedge clk); #1;
    iv1 = 1'b0; iv8 = 1'b0; iv32 = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1; iv1 = 1'b1; iv8 = 1'b1; iv32 = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; iv1 = 1'b0; iv8 = 1'b0; iv32 = 1'b0;
    chk("abort_out_valid", W'({ov32, ov8, ov1}), W'(0));
    chk("abort_z_d1", z1, '0);
    chk("abort_z_d8", z8, '0);
    chk("abort_z_d32", z32, '0);
    chk("abort_in_ready", W'({ir32, ir8, ir1}), W'(3'b111));
    nov = 0;
    for (int c = 0; c < 140; c++) begin
      @(posedge clk); #1;
      if (ov1 || ov8 || ov32) nov++;
    end
    chk("abort_no_result", W'(nov), W'(0));
    prev_z8 = '0;
    run_op(128'h3, 128'h3, 3'b111);
    check_res("after_abort", 3'b111, 128'h5);

`ifdef GF_MULT_ACCUM_EN
    in_acc = 1'b0;
    run_op(128'h1, 128'h3, 3'b111);
    check_res("accum_op1", 3'b111, 128'h3);
    in_acc = 1'b1;
    run_op(128'h1, 128'h5, 3'b111);
    check_res("accum_op2", 3'b111, 128'h6);
    in_acc = 1'b0;
`endif

    // Random operands; the bit-serial instance joins every fourth pair.
    for (int i = 0; i < 1000; i++) begin
      ra = {$urandom, $urandom, $urandom, $urandom};
      rb = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(15) == 0) rb = '0;
      if ($urandom_range(31) == 0) ra = {1'b1, 127'h0};
      m = (i % 4 == 0) ? 3'b111 : 3'b110;
      run_op(ra, rb, m);
      check_res($sformatf("rand%0d", i), m, ref_mul(ra, rb));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
